// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: picks the highest-priority PC redirect, holds it until the PC generator accepts it,
// and advances the fetch epoch on each accepted redirect so stale fetch packets are dropped.
module fetch_redirect_ctrl #(
    parameter int EPOCH_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exc_valid_i,
    input  logic [31:0]        exc_target_i,
    input  logic               br_valid_i,
    input  logic [31:0]        br_target_i,
    input  logic               pd_valid_i,
    input  logic [31:0]        pd_target_i,
    input  logic               fetch_ready_i,
    output logic               redir_valid_o,
    output logic [31:0]        redir_target_o,
    output logic [1:0]         redir_src_o,
    output logic               kill_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_nx;
    logic [31:0]        target_nx;
    logic [1:0]         src_nx, win_src;
    logic [31:0]        win_tgt;
    logic               xfer, capture;
    logic [EPOCH_W-1:0] epoch_nx;

    always_comb begin
        win_src   = exc_valid_i ? 2'd3 : br_valid_i ? 2'd2 : pd_valid_i ? 2'd1 : 2'd0;
        win_tgt   = exc_valid_i ? exc_target_i : br_valid_i ? br_target_i : pd_target_i;
        xfer      = (state == HOLD) && fetch_ready_i;
        // While holding without a transfer, only an equal-or-higher priority request may replace the entry
        capture   = (win_src != 2'd0) && (state == IDLE || xfer || win_src >= redir_src_o);
        state_nx  = capture ? HOLD : xfer ? IDLE : state;
        src_nx    = capture ? win_src : xfer ? 2'd0 : redir_src_o;
        target_nx = capture ? win_tgt : redir_target_o;
        epoch_nx  = epoch_o + EPOCH_W'(xfer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            redir_target_o <= 32'h0;
            redir_src_o    <= 2'd0;
            kill_o         <= 1'b0;
            epoch_o        <= '0;
        end else begin
            state          <= state_nx;
            redir_target_o <= target_nx;
            redir_src_o    <= src_nx;
            kill_o         <= capture;
            epoch_o        <= epoch_nx;
        end
    end

    assign redir_valid_o = (state == HOLD);
    assign busy_o        = (state == HOLD);
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: table-driven directed vectors plus hand sequences for async reset and epoch wrap.
module tb_fetch_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exc_valid_i = 1'b0, br_valid_i = 1'b0, pd_valid_i = 1'b0, fetch_ready_i = 1'b0;
    logic [31:0] exc_target_i = '0, br_target_i = '0, pd_target_i = '0;
    logic        redir_valid_o, kill_o, busy_o;
    logic [31:0] redir_target_o;
    logic [1:0]  redir_src_o;
    logic [2:0]  epoch_o;

    int errors = 0;
    int checks = 0;

    fetch_redirect_ctrl #(.EPOCH_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid_i(exc_valid_i), .exc_target_i(exc_target_i),
        .br_valid_i(br_valid_i), .br_target_i(br_target_i),
        .pd_valid_i(pd_valid_i), .pd_target_i(pd_target_i),
        .fetch_ready_i(fetch_ready_i),
        .redir_valid_o(redir_valid_o), .redir_target_o(redir_target_o),
        .redir_src_o(redir_src_o), .kill_o(kill_o), .epoch_o(epoch_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev; logic [31:0] et;
        logic        bv; logic [31:0] bt;
        logic        pv; logic [31:0] pt;
        logic        rdy;
        logic        v; logic [31:0] t; logic [1:0] s; logic k; logic [2:0] e;
    } vec_t;

    vec_t vec [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] t, input logic [1:0] s,
                             input logic k, input logic [2:0] e);
        check({tag, ".valid"}, 32'(redir_valid_o), 32'(v));
        check({tag, ".target"}, redir_target_o, t);
        check({tag, ".src"}, 32'(redir_src_o), 32'(s));
        check({tag, ".kill"}, 32'(kill_o), 32'(k));
        check({tag, ".epoch"}, 32'(epoch_o), 32'(e));
        check({tag, ".busy"}, 32'(busy_o), 32'(v));
    endtask

    task automatic drive(input logic ev, input logic [31:0] et, input logic bv, input logic [31:0] bt,
                         input logic pv, input logic [31:0] pt, input logic rdy);
        exc_valid_i = ev; exc_target_i = et;
        br_valid_i = bv; br_target_i = bt;
        pd_valid_i = pv; pd_target_i = pt;
        fetch_ready_i = rdy;
    endtask

    initial begin
        // ev et bv bt pv pt rdy | valid target src kill epoch
        vec[0]  = '{0, 32'h0,         1, 32'h1c00_0040, 0, 32'h0,         1, 1, 32'h1c00_0040, 2, 1, 0};
        vec[1]  = '{0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0, 32'h1c00_0040, 0, 0, 1};
        vec[2]  = '{1, 32'h1c00_8000, 1, 32'h1c00_0100, 1, 32'h1c00_0200, 0, 1, 32'h1c00_8000, 3, 1, 1};
        vec[3]  = '{0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 1, 32'h1c00_8000, 3, 0, 1};
        vec[4]  = '{0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0, 32'h1c00_8000, 0, 0, 2};
        vec[5]  = '{0, 32'h0,         1, 32'h1c00_0300, 0, 32'h0,         0, 1, 32'h1c00_0300, 2, 1, 2};
        vec[6]  = '{0, 32'h0,         0, 32'h0,         1, 32'h1c00_0400, 0, 1, 32'h1c00_0300, 2, 0, 2};
        vec[7]  = '{1, 32'h1c00_9000, 0, 32'h0,         0, 32'h0,         0, 1, 32'h1c00_9000, 3, 1, 2};
        vec[8]  = '{1, 32'h1c00_a000, 0, 32'h0,         0, 32'h0,         0, 1, 32'h1c00_a000, 3, 1, 2};
        vec[9]  = '{0, 32'h0,         0, 32'h0,         1, 32'h1c00_0500, 1, 1, 32'h1c00_0500, 1, 1, 3};
        vec[10] = '{0, 32'h0,         1, 32'h1c00_0600, 0, 32'h0,         0, 1, 32'h1c00_0600, 2, 1, 3};
        vec[11] = '{0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0, 32'h1c00_0600, 0, 0, 4};
        vec[12] = '{0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 0, 32'h1c00_0600, 0, 0, 4};

        #12;
        check_all("reset", 0, 32'h0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("idle", 0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].ev, vec[i].et, vec[i].bv, vec[i].bt, vec[i].pv, vec[i].pt, vec[i].rdy);
            @(posedge clk); #1;
            check_all($sformatf("v%0d", i), vec[i].v, vec[i].t, vec[i].s, vec[i].k, vec[i].e);
        end

        // Async reset while holding: outputs clear without a clock edge
        drive(0, 0, 1, 32'h1c00_0700, 0, 0, 0);
        @(posedge clk); #1;
        check_all("prerst", 1, 32'h1c00_0700, 2, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all("midrst", 0, 32'h0, 0, 0, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_all($sformatf("postrst%0d", i), 0, 32'h0, 0, 0, 0);
        end

        // Nine consecutive transfers from epoch 0 must wrap through 0 and finish at 1
        begin
            logic [2:0] exp_e;
            exp_e = 3'd0;
            for (int i = 0; i < 10; i++) begin
                if (i < 9) drive(0, 0, 0, 0, 1, 32'h1c01_0000 + 32'(i * 4), 1);
                else       drive(0, 0, 0, 0, 0, 0, 1);
                @(posedge clk); #1;
                if (i > 0) exp_e = exp_e + 3'd1;
                if (i < 9) check_all($sformatf("wrap%0d", i), 1, 32'h1c01_0000 + 32'(i * 4), 1, 1, exp_e);
                else       check_all("wrapend", 0, 32'h1c01_0020, 0, 0, exp_e);
            end
            check("wrap.final", 32'(epoch_o), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
